// File: rtl/tank_game_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tank_game_pkg
// Brief    : Shared types, status codes and box sizes for the tank game blocks.
// Revision : 1.0
// ============================================================================
package tank_game_pkg;

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        HIT  = 2'd1,
        OVER = 2'd2
    } ref_state_t;

    localparam logic [1:0] HIT_ACTIVE = 2'b01;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P0   = 2'b01;
    localparam logic [1:0] WIN_P1   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam int TANK_W_DEF   = 32;
    localparam int TANK_H_DEF   = 32;
    localparam int BULLET_W_DEF = 8;
    localparam int BULLET_H_DEF = 8;

    // A player wins when the opponent is out of lives; both out is a draw.
    function automatic logic [1:0] winner_code(input logic p0_out, input logic p1_out);
        case ({p0_out, p1_out})
            2'b01:   return WIN_P0;
            2'b10:   return WIN_P1;
            2'b11:   return WIN_DRAW;
            default: return WIN_NONE;
        endcase
    endfunction

    function automatic logic [1:0] dec_sat(input logic [1:0] value, input logic hit);
        return (hit && value != 2'd0) ? value - 2'd1 : value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aabb_overlap.sv
`default_nettype none
// ============================================================================
// Module   : aabb_overlap
// Brief    : Inclusive axis-aligned box overlap test between a bullet and a tank.
// Revision : 1.0
// ============================================================================
module aabb_overlap
    import tank_game_pkg::*;
#(
    parameter int TANK_W   = TANK_W_DEF,
    parameter int TANK_H   = TANK_H_DEF,
    parameter int BULLET_W = BULLET_W_DEF,
    parameter int BULLET_H = BULLET_H_DEF
) (
    input  logic [9:0] bullet_X,
    input  logic [9:0] bullet_Y,
    input  logic [9:0] tank_X,
    input  logic [9:0] tank_Y,
    output logic       overlap
);

    // 11-bit sums so a box near the right/bottom edge cannot wrap around.
    logic [10:0] w_bx;
    logic [10:0] w_by;
    logic [10:0] w_tx;
    logic [10:0] w_ty;
    logic [10:0] w_tx_max;
    logic [10:0] w_ty_max;
    logic [10:0] w_bx_max;
    logic [10:0] w_by_max;

    assign w_bx     = {1'b0, bullet_X};
    assign w_by     = {1'b0, bullet_Y};
    assign w_tx     = {1'b0, tank_X};
    assign w_ty     = {1'b0, tank_Y};
    assign w_tx_max = w_tx + 11'(TANK_W);
    assign w_ty_max = w_ty + 11'(TANK_H);
    assign w_bx_max = w_bx + 11'(BULLET_W);
    assign w_by_max = w_by + 11'(BULLET_H);

    assign overlap = (w_bx <= w_tx_max) && (w_bx_max >= w_tx) &&
                     (w_by <= w_ty_max) && (w_by_max >= w_ty);

endmodule
`default_nettype wire

// File: rtl/tank_hit_referee.sv
`default_nettype none
// ============================================================================
// Module   : tank_hit_referee
// Brief    : Per-frame bullet/tank hit referee: lives, invulnerability blink,
//            bullet removal, respawn and game-over/winner.
// Revision : 1.0
// ============================================================================
module tank_hit_referee
    import tank_game_pkg::*;
#(
    parameter int TANK_W        = TANK_W_DEF,
    parameter int TANK_H        = TANK_H_DEF,
    parameter int BULLET_W      = BULLET_W_DEF,
    parameter int BULLET_H      = BULLET_H_DEF,
    parameter int LIVES_INIT    = 3,
    parameter int INVULN_FRAMES = 60,
    parameter int FLASH_PERIOD  = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       restart,
    input  logic [9:0] tank0_X,
    input  logic [9:0] tank0_Y,
    input  logic [9:0] tank1_X,
    input  logic [9:0] tank1_Y,
    input  logic [9:0] bullet0_X,
    input  logic [9:0] bullet0_Y,
    input  logic [9:0] bullet1_X,
    input  logic [9:0] bullet1_Y,
    input  logic [1:0] hit0,
    input  logic [1:0] hit1,
    output logic [1:0] bullet_kill,
    output logic [1:0] respawn,
    output logic [1:0] lives0,
    output logic [1:0] lives1,
    output logic [1:0] flash,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam int FLASH_BIT = $clog2(FLASH_PERIOD);
    localparam int INV_BITS  = $clog2(INVULN_FRAMES);
    localparam int CNT_W     = (INV_BITS > FLASH_BIT) ? INV_BITS : FLASH_BIT + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INVULN_FRAMES - 1);
    localparam logic [1:0] LIVES_RST = 2'(LIVES_INIT);

    logic             r_frame_sync;
    logic             r_frame_d;
    logic             r_tick;
    ref_state_t       r_state;
    logic [CNT_W-1:0] r_count;
    logic [1:0]       r_victim;

    logic             w_ovl_a;
    logic             w_ovl_b;
    logic             w_hit_a;
    logic             w_hit_b;
    logic [1:0]       w_lives0_next;
    logic [1:0]       w_lives1_next;
    logic [CNT_W-1:0] w_count_inc;

    // hitA: player-0 bullet on tank 1; hitB: player-1 bullet on tank 0.
    aabb_overlap #(
        .TANK_W   (TANK_W),
        .TANK_H   (TANK_H),
        .BULLET_W (BULLET_W),
        .BULLET_H (BULLET_H)
    ) u_ovl_a (
        .bullet_X (bullet0_X),
        .bullet_Y (bullet0_Y),
        .tank_X   (tank1_X),
        .tank_Y   (tank1_Y),
        .overlap  (w_ovl_a)
    );

    aabb_overlap #(
        .TANK_W   (TANK_W),
        .TANK_H   (TANK_H),
        .BULLET_W (BULLET_W),
        .BULLET_H (BULLET_H)
    ) u_ovl_b (
        .bullet_X (bullet1_X),
        .bullet_Y (bullet1_Y),
        .tank_X   (tank0_X),
        .tank_Y   (tank0_Y),
        .overlap  (w_ovl_b)
    );

    assign w_hit_a       = (hit0 == HIT_ACTIVE) && w_ovl_a;
    assign w_hit_b       = (hit1 == HIT_ACTIVE) && w_ovl_b;
    assign w_lives1_next = dec_sat(lives1, w_hit_a);
    assign w_lives0_next = dec_sat(lives0, w_hit_b);
    assign w_count_inc   = r_count + 1'b1;

    // frame_clk is asynchronous: sample it once, then edge-detect the sampled copy.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_frame_sync <= 1'b0;
            r_frame_d    <= 1'b0;
            r_tick       <= 1'b0;
        end else begin
            r_frame_sync <= frame_clk;
            r_frame_d    <= r_frame_sync;
            r_tick       <= r_frame_sync & ~r_frame_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= PLAY;
            r_count     <= '0;
            r_victim    <= 2'b00;
            lives0      <= LIVES_RST;
            lives1      <= LIVES_RST;
            bullet_kill <= 2'b00;
            respawn     <= 2'b00;
            flash       <= 2'b00;
            game_over   <= 1'b0;
            winner      <= WIN_NONE;
        end else begin
            bullet_kill <= 2'b00;
            respawn     <= 2'b00;
            if (r_tick) begin
                case (r_state)
                    PLAY: begin
                        if (w_hit_a || w_hit_b) begin
                            lives0      <= w_lives0_next;
                            lives1      <= w_lives1_next;
                            bullet_kill <= {w_hit_b, w_hit_a};
                            r_count     <= '0;
                            flash       <= 2'b00;
                            if (w_lives0_next == 2'd0 || w_lives1_next == 2'd0) begin
                                r_state   <= OVER;
                                r_victim  <= 2'b00;
                                game_over <= 1'b1;
                                winner    <= winner_code(w_lives0_next == 2'd0,
                                                         w_lives1_next == 2'd0);
                            end else begin
                                r_state  <= HIT;
                                r_victim <= {w_hit_a, w_hit_b};
                            end
                        end
                    end
                    HIT: begin
                        if (r_count == CNT_LAST) begin
                            respawn  <= r_victim;
                            flash    <= 2'b00;
                            r_victim <= 2'b00;
                            r_count  <= '0;
                            r_state  <= PLAY;
                        end else begin
                            // Blink phase follows the post-increment frame count.
                            r_count <= w_count_inc;
                            flash   <= r_victim & {2{w_count_inc[FLASH_BIT]}};
                        end
                    end
                    OVER: begin
                        if (restart) begin
                            lives0    <= LIVES_RST;
                            lives1    <= LIVES_RST;
                            respawn   <= 2'b11;
                            winner    <= WIN_NONE;
                            game_over <= 1'b0;
                            r_count   <= '0;
                            r_victim  <= 2'b00;
                            r_state   <= PLAY;
                        end
                    end
                    default: begin
                        r_state <= PLAY;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tank_hit_referee.sv
`default_nettype none
// ============================================================================
// Module   : tb_tank_hit_referee
// Brief    : Directed + randomized self-checking bench for tank_hit_referee.
// Revision : 1.0
// ============================================================================
module tb_tank_hit_referee;

    localparam int LIVES  = 3;
    localparam int INVULN = 60;
    localparam int FLASH  = 4;
    localparam int TW = 32, TH = 32, BW = 8, BH = 8;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_clk = 1'b0;
    logic       restart = 1'b0;
    logic [9:0] tank0_X = 10'd500, tank0_Y = 10'd400;
    logic [9:0] tank1_X = 10'd190, tank1_Y = 10'd90;
    logic [9:0] bullet0_X = 10'd0, bullet0_Y = 10'd0;
    logic [9:0] bullet1_X = 10'd0, bullet1_Y = 10'd0;
    logic [1:0] hit0 = 2'b00, hit1 = 2'b00;
    logic [1:0] bullet_kill, respawn, lives0, lives1, flash, winner;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    // Reference model: lives, frames elapsed since last hit (-1 = vulnerable), who is blinking.
    int         m_l0, m_l1, m_age;
    bit         m_over;
    logic [1:0] m_victim, m_win, m_flash;

    always #10 Clk = ~Clk;

    tank_hit_referee dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .restart     (restart),
        .tank0_X     (tank0_X),
        .tank0_Y     (tank0_Y),
        .tank1_X     (tank1_X),
        .tank1_Y     (tank1_Y),
        .bullet0_X   (bullet0_X),
        .bullet0_Y   (bullet0_Y),
        .bullet1_X   (bullet1_X),
        .bullet1_Y   (bullet1_Y),
        .hit0        (hit0),
        .hit1        (hit1),
        .bullet_kill (bullet_kill),
        .respawn     (respawn),
        .lives0      (lives0),
        .lives1      (lives1),
        .flash       (flash),
        .game_over   (game_over),
        .winner      (winner)
    );

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit boxes_touch(int bx, int by, int tx, int ty);
        return (bx <= tx + TW) && (bx + BW >= tx) && (by <= ty + TH) && (by + BH >= ty);
    endfunction

    task automatic model_reset();
        m_l0 = LIVES; m_l1 = LIVES; m_age = -1; m_over = 0;
        m_victim = 2'b00; m_win = 2'b00; m_flash = 2'b00;
    endtask

    // Advance the model by one frame using the current inputs.
    task automatic model_step(output logic [1:0] ek, output logic [1:0] er);
        bit ha, hb;
        ek = 2'b00; er = 2'b00;
        if (m_over) begin
            if (restart) begin
                m_l0 = LIVES; m_l1 = LIVES; m_over = 0; m_win = 2'b00; er = 2'b11;
            end
        end else if (m_age >= 0) begin
            if (m_age == INVULN - 1) begin
                er = m_victim; m_victim = 2'b00; m_age = -1; m_flash = 2'b00;
            end else begin
                m_age++;
                m_flash = ((m_age / FLASH) % 2 == 1) ? m_victim : 2'b00;
            end
        end else begin
            ha = (hit0 == 2'b01) && boxes_touch(bullet0_X, bullet0_Y, tank1_X, tank1_Y);
            hb = (hit1 == 2'b01) && boxes_touch(bullet1_X, bullet1_Y, tank0_X, tank0_Y);
            if (ha || hb) begin
                if (ha && m_l1 > 0) m_l1--;
                if (hb && m_l0 > 0) m_l0--;
                ek = {hb, ha};
                if (m_l0 == 0 || m_l1 == 0) begin
                    m_over = 1;
                    m_win = {m_l0 == 0, m_l1 == 0};
                end else begin
                    m_age = 0; m_victim = {ha, hb}; m_flash = 2'b00;
                end
            end
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_lives0"}, 8'(lives0), 8'(m_l0));
        chk({tag, "_lives1"}, 8'(lives1), 8'(m_l1));
        chk({tag, "_flash"}, 8'(flash), 8'(m_flash));
        chk({tag, "_over"}, 8'(game_over), 8'(m_over));
        chk({tag, "_winner"}, 8'(winner), 8'(m_win));
    endtask

    task automatic do_tick(input string tag);
        logic [1:0] ek, er;
        model_step(ek, er);
        @(negedge Clk); frame_clk = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk({tag, "_kill"}, 8'(bullet_kill), 8'(ek));
        chk({tag, "_respawn"}, 8'(respawn), 8'(er));
        check_state(tag);
        @(posedge Clk); #1;
        chk({tag, "_kill_end"}, 8'(bullet_kill), 8'h00);
        chk({tag, "_resp_end"}, 8'(respawn), 8'h00);
        @(negedge Clk); frame_clk = 1'b0;
        repeat (2) @(posedge Clk);
    endtask

    task automatic do_reset(input string tag);
        @(negedge Clk); Reset = 1'b1; frame_clk = 1'b0;
        @(posedge Clk); #1;
        model_reset();
        check_state(tag);
        chk({tag, "_kill"}, 8'(bullet_kill), 8'h00);
        chk({tag, "_respawn"}, 8'(respawn), 8'h00);
        @(negedge Clk); Reset = 1'b0;
        repeat (3) begin
            @(posedge Clk); #1;
            chk({tag, "_no_resp"}, 8'(respawn), 8'h00);
        end
    endtask

    function automatic logic [9:0] near(int t);
        int v;
        v = t + int'($urandom_range(0, 70)) - 35;
        if (v < 0) v = 0;
        return 10'(v);
    endfunction

    initial begin
        model_reset();
        repeat (2) @(posedge Clk);
        do_reset("reset");

        // Direct hit on tank 1.
        bullet0_X = 10'd200; bullet0_Y = 10'd100; hit0 = 2'b01;
        do_tick("t1_hit");
        chk("t1_lives1_const", 8'(lives1), 8'd2);

        // Overlap held through invulnerability, then respawn.
        repeat (59) do_tick("t3_inv");
        do_tick("t3_end");
        chk("t3_flash_clear", 8'(flash), 8'h00);
        hit0 = 2'b00;

        // Inclusive right edge: 126+32 = 158 hits, 159 misses.
        tank1_X = 10'd126; bullet0_X = 10'd158; hit0 = 2'b01;
        do_tick("t2_edge");
        chk("t2_edge_const", 8'(lives1), 8'd1);
        hit0 = 2'b00;
        repeat (60) do_tick("t2_inv");
        bullet0_X = 10'd159; hit0 = 2'b01;
        do_tick("t2_miss");

        // Bullet over its own tank.
        bullet0_X = 10'd510; bullet0_Y = 10'd410;
        do_tick("t7_own");
        chk("t7_lives0_const", 8'(lives0), 8'd3);
        hit0 = 2'b00;

        // Bring player 0 down to one life.
        bullet1_X = 10'd505; bullet1_Y = 10'd405;
        repeat (2) begin
            hit1 = 2'b01; do_tick("t4_pre");
            hit1 = 2'b00; repeat (60) do_tick("t4_inv");
        end

        // Simultaneous final hits: draw.
        bullet0_X = 10'd130; bullet0_Y = 10'd95; hit0 = 2'b01; hit1 = 2'b01;
        do_tick("t4_sim");
        chk("t4_winner_const", 8'(winner), 8'h03);
        hit0 = 2'b00; hit1 = 2'b00;

        // Restart is only honoured on a tick.
        restart = 1'b1;
        repeat (10) @(posedge Clk);
        #1;
        chk("t5_hold_over", 8'(game_over), 8'h01);
        chk("t5_hold_resp", 8'(respawn), 8'h00);
        do_tick("t5_restart");
        restart = 1'b0;

        // Reset in the middle of an invulnerability window.
        hit0 = 2'b01;
        do_tick("t6_hit");
        hit0 = 2'b00;
        repeat (30) do_tick("t6_inv");
        do_reset("t6_reset");

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 59) == 0) do_reset("rnd_reset");
            tank0_X = 10'($urandom_range(0, 600)); tank0_Y = 10'($urandom_range(0, 440));
            tank1_X = 10'($urandom_range(0, 600)); tank1_Y = 10'($urandom_range(0, 440));
            bullet0_X = near(tank1_X); bullet0_Y = near(tank1_Y);
            bullet1_X = near(tank0_X); bullet1_Y = near(tank0_Y);
            hit0 = ($urandom_range(0, 2) != 0) ? 2'b01 : 2'($urandom_range(0, 3));
            hit1 = ($urandom_range(0, 2) != 0) ? 2'b01 : 2'($urandom_range(0, 3));
            restart = 1'($urandom_range(0, 1));
            do_tick("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
